// File: rtl/instr_fetch.sv
// Instruction fetch stage: writable program memory, PC and run/step/stop
// control feeding one registered instruction per enabled cycle to the decoder.
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int ADDR_W = 4,
    parameter logic [7:0] HALT_WORD = 8'hFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ena,
    input  logic              run,
    input  logic              step,
    input  logic              stop,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [7:0]        instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [7:0]        next_out;
    logic              next_valid;
    logic              fetch;
    logic              write_ok;
    logic [7:0]        word;
    logic [7:0]        mem [DEPTH];

    assign word   = mem[pc];
    assign pc_out = pc;

    // Next-state decode: control priority run > step > stop, then fetch.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_out   = instr_out;
        next_valid = 1'b0;
        fetch      = 1'b0;
        write_ok   = 1'b0;
        unique case (state)
            IDLE: begin
                write_ok = prog_we && !run && !step;
                if (run) begin
                    next_state = RUN;
                    next_pc    = '0;
                end else if (step) begin
                    next_state = STEP;
                end
            end
            RUN: begin
                if (run) begin
                    next_pc = '0;
                end else if (stop && !step) begin
                    next_state = IDLE;
                end else if (ena) begin
                    fetch = 1'b1;
                end
            end
            STEP: begin
                fetch      = 1'b1;
                next_state = IDLE;
            end
            HALT: begin
                write_ok = prog_we && !run && !step;
                if (run) begin
                    next_state = RUN;
                    next_pc    = '0;
                end
            end
            default: next_state = IDLE;
        endcase
        if (fetch) begin
            if (word == HALT_WORD) begin
                next_state = HALT;
            end else begin
                next_out   = word;
                next_valid = 1'b1;
                next_pc    = pc + 1'b1;
            end
        end
    end

    // State, PC, registered outputs and program memory.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= 8'h00;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            instr_out   <= next_out;
            instr_valid <= next_valid;
            halted      <= (next_state == HALT);
            if (write_ok) begin
                mem[prog_addr] <= prog_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ena = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       stop = 1'b0;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic [3:0] pc_out;
    logic       halted;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    instr_fetch dut (
        .clock(clock),
        .reset_n(reset_n),
        .ena(ena),
        .run(run),
        .step(step),
        .stop(stop),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc_out(pc_out),
        .halted(halted)
    );

    always #5 clock = ~clock;

    // Behavioural model
    typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;
    mode_t      mode = M_IDLE;
    logic [7:0] m_mem [16];
    int         m_pc = 0;
    logic [7:0] m_out = 8'h00;
    bit         m_valid = 0;
    bit         m_halted = 0;
    bit         m_fetch;
    bit         m_write;

    always @(posedge clock) begin
        if (!reset_n) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_pc    = 0;
            m_out   = 8'h00;
            m_valid = 0;
            mode    = M_IDLE;
        end else begin
            m_fetch = 0;
            m_valid = 0;
            m_write = prog_we && !run && !step &&
                      (mode == M_IDLE || mode == M_HALT);
            case (mode)
                M_IDLE:
                    if (run) begin mode = M_RUN; m_pc = 0; end
                    else if (step) mode = M_STEP;
                M_HALT:
                    if (run) begin mode = M_RUN; m_pc = 0; end
                M_RUN:
                    if (run) m_pc = 0;
                    else if (stop && !step) mode = M_IDLE;
                    else if (ena) m_fetch = 1;
                M_STEP: begin
                    m_fetch = 1;
                    mode = M_IDLE;
                end
            endcase
            if (m_fetch) begin
                if (m_mem[m_pc] == 8'hFF) begin
                    mode = M_HALT;
                end else begin
                    m_out   = m_mem[m_pc];
                    m_valid = 1;
                    m_pc    = (m_pc + 1) % 16;
                end
            end
            if (m_write) m_mem[prog_addr] = prog_data;
        end
        m_halted = (mode == M_HALT);
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            checks += 4;
            if (instr_out !== m_out) begin
                errors++;
                $display("FAIL model_out t=%0t: got %h expected %h",
                         $time, instr_out, m_out);
            end
            if (instr_valid !== m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t: got %b expected %b",
                         $time, instr_valid, m_valid);
            end
            if (int'(pc_out) != m_pc || $isunknown(pc_out)) begin
                errors++;
                $display("FAIL model_pc t=%0t: got %0d expected %0d",
                         $time, pc_out, m_pc);
            end
            if (halted !== m_halted) begin
                errors++;
                $display("FAIL model_halted t=%0t: got %b expected %b",
                         $time, halted, m_halted);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        cyc(1);
        prog_we = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        cyc(1);
        run = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        // Reset
        cyc(2);
        reset_n = 1'b1;
        chk_en  = 1;
        lit("rst_out", instr_out, 8'h00);
        lit("rst_valid", instr_valid, 0);
        lit("rst_pc", pc_out, 0);
        lit("rst_halted", halted, 0);

        // Load and run
        write(0, 8'h03);
        write(1, 8'h25);
        write(2, 8'hFF);
        ena = 1'b1;
        pulse_run();
        lit("run_lat_valid", instr_valid, 0);
        cyc(1);
        lit("run_w0", {instr_valid, instr_out}, {1'b1, 8'h03});
        cyc(1);
        lit("run_w1", {instr_valid, instr_out}, {1'b1, 8'h25});
        cyc(1);
        lit("halt_valid", instr_valid, 0);
        lit("halt_flag", halted, 1);
        lit("halt_pc", pc_out, 2);

        // Stall
        write(2, 8'h31);
        write(3, 8'h32);
        write(4, 8'hFF);
        pulse_run();
        cyc(1);
        lit("stall_pre", instr_out, 8'h03);
        ena = 1'b0;
        cyc(3);
        lit("stall_valid", instr_valid, 0);
        lit("stall_pc", pc_out, 1);
        lit("stall_out", instr_out, 8'h03);
        ena = 1'b1;
        cyc(1);
        lit("stall_resume", {instr_valid, instr_out}, {1'b1, 8'h25});
        cyc(1);
        lit("stall_next", instr_out, 8'h31);
        cyc(2);
        lit("stall_halt", halted, 1);

        // Wrap
        for (int i = 0; i < 16; i++) write(4'(i), 8'(8'h10 + i));
        pulse_run();
        cyc(16);
        lit("wrap_last", instr_out, 8'h1F);
        lit("wrap_pc0", pc_out, 0);
        cyc(2);
        lit("wrap_again", instr_out, 8'h11);
        lit("wrap_pc2", pc_out, 2);

        // Stop in RUN
        pulse_stop();
        lit("stop_pc", pc_out, 2);
        lit("stop_valid", instr_valid, 0);
        cyc(2);
        lit("stop_idle_pc", pc_out, 2);

        // Single-step from PC 0 (run then immediate stop)
        pulse_run();
        pulse_stop();
        lit("rewind_pc", pc_out, 0);
        pulse_step();
        lit("step1_lat", instr_valid, 0);
        cyc(1);
        lit("step1", {instr_valid, instr_out}, {1'b1, 8'h10});
        cyc(1);
        lit("step1_once", instr_valid, 0);
        cyc(1);
        pulse_step();
        cyc(1);
        lit("step2", {instr_valid, instr_out}, {1'b1, 8'h11});
        lit("step2_pc", pc_out, 2);

        // Write protection: during RUN, and together with run
        pulse_run();
        prog_we = 1'b1; prog_addr = 0; prog_data = 8'hAA;
        cyc(2);
        prog_we = 1'b0;
        pulse_stop();
        run = 1'b1; prog_we = 1'b1; prog_addr = 1; prog_data = 8'hBB;
        cyc(1);
        run = 1'b0; prog_we = 1'b0;
        pulse_stop();
        pulse_step();
        cyc(1);
        lit("prot_m0", instr_out, 8'h10);
        pulse_step();
        cyc(1);
        lit("prot_m1", instr_out, 8'h11);

        // run and step together
        run = 1'b1; step = 1'b1;
        cyc(1);
        run = 1'b0; step = 1'b0;
        cyc(1);
        lit("prio_out", instr_out, 8'h10);
        lit("prio_pc", pc_out, 1);
        cyc(2);

        // Reset mid-run
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        lit("mrst_out", instr_out, 8'h00);
        lit("mrst_valid", instr_valid, 0);
        lit("mrst_pc", pc_out, 0);
        lit("mrst_halted", halted, 0);
        pulse_step();
        cyc(1);
        lit("mrst_step", {instr_valid, instr_out}, {1'b1, 8'h00});
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the instruction decoder. It holds a small writable program memory and a program counter (PC). Under run, step and stop control it presents one 8-bit instruction per enabled cycle on `instr_out`, qualified by `instr_valid`, which drives the decoder's `instr_in`/`ena` pair. Program load, single-step and halt detection are handled here so the decoder stays a pure registered translator.

## Interface
- `DEPTH`, 16: number of 8-bit program words. Power of two.
- `ADDR_W`, 4: PC and program address width; equals log2(`DEPTH`).
- `HALT_WORD`, 8'hFF: reserved encoding that stops fetching. It is never forwarded to the decoder.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  global enable; 0 stalls fetch in RUN.
- `run`  in  1  pulse; starts continuous fetch from address 0.
- `step`  in  1  pulse; fetches exactly one instruction at the current PC.
- `stop`  in  1  pulse; leaves RUN with the PC preserved.
- `prog_we`  in  1  program memory write strobe.
- `prog_addr`  in  ADDR_W  program write address.
- `prog_data`  in  8  program write data.
- `instr_out`  out  8  fetched instruction, registered.
- `instr_valid`  out  1  `instr_out` is a new instruction this cycle; connects to decoder `ena`.
- `pc_out`  out  ADDR_W  address of the next word to be fetched.
- `halted`  out  1  high while in HALT.

## Operation
- States: IDLE, RUN, STEP, HALT. Reset state is IDLE.
- **Reset** (`reset_n`=0 at a rising edge):
  - state=IDLE, PC=0, `instr_out`=8'h00, `instr_valid`=0, `halted`=0.
  - All memory words are cleared to 8'h00.
- **Program load:**
  - `prog_we` is honoured only in IDLE or HALT, and only when `run` and `step` are both 0 in the same cycle: mem[`prog_addr`] <= `prog_data`.
  - In every other case the write is silently dropped.
- **Control priority** (per cycle): `run` over `step` over `stop`.
- **IDLE:**
  - `run` -> RUN with PC <= 0.
  - `step` -> STEP.
  - `stop` has no effect.
- **RUN, `ena`=1:**
  - Read w = mem[PC].
  - If w != `HALT_WORD`: `instr_out` <= w, `instr_valid` <= 1, PC <= PC+1 mod `DEPTH` (15 wraps to 0).
  - If w == `HALT_WORD`: `instr_valid` <= 0, `instr_out` holds, PC holds (it points at the halt word), state <= HALT.
- **RUN, `ena`=0:** `instr_valid` <= 0; `instr_out` and PC hold; state unchanged.
- **RUN, `stop`:** -> IDLE. No fetch that cycle, `instr_valid` <= 0, PC holds.
- **STEP:**
  - Performs one fetch using the RUN rules, regardless of `ena`.
  - Returns to IDLE, or goes to HALT if the word is `HALT_WORD`.
  - `run`, `step` and `stop` are ignored while in STEP.
- **HALT:**
  - `halted`=1.
  - `run` -> RUN with PC <= 0.
  - `step` and `stop` are ignored.
- `halted` is registered: it is 1 exactly while state==HALT.

## Timing
- Fetch latency is 1 cycle. A fetch decided at edge N presents `instr_out`/`instr_valid` after edge N, so the decoder registers it at edge N+1.
- `run` sampled at edge N (from IDLE/HALT): state=RUN after N. The first fetch of mem[0] happens at edge N+1, so `instr_valid`=1 after N+1 if `ena`=1.
- `step` sampled at edge N (from IDLE): STEP after N, fetch at N+1, IDLE after N+1. `instr_valid` is high for exactly one cycle.
- `instr_valid` is never high for two consecutive cycles unless RUN with `ena`=1 on consecutive edges.
- `pc_out` is the registered PC and updates on the same edge as `instr_out`.
- Reset asserted mid-RUN takes effect at the next edge. `instr_valid` drops in that cycle, and the memory contents are lost.

## Test plan
- **Load and run:**
  - Stimulus: reset; write mem[0..2]=8'h03,8'h25,8'hFF; pulse `run`; hold `ena`=1.
  - Required: `instr_out`=8'h03 then 8'h25 with `instr_valid`=1 on two consecutive cycles; then `instr_valid`=0, `halted`=1, `pc_out`=2.
- **Stall:**
  - Stimulus: mid-RUN, drop `ena` for 3 cycles.
  - Required: `instr_valid`=0, `pc_out` and `instr_out` frozen; on re-enable the next word follows with none skipped or duplicated.
- **Wrap:**
  - Stimulus: fill all 16 words with 8'h10+i (no halt word); run for 18 enabled cycles.
  - Required: `instr_out` sequence is 8'h10..8'h1F, 8'h10, 8'h11; `pc_out` goes 15 -> 0.
- **Single-step and stop:**
  - Stimulus: from IDLE, pulse `step` twice, 3 cycles apart.
  - Required: one `instr_valid` pulse each, with mem[0] then mem[1]; `pc_out` ends at 2.
  - Stimulus: pulse `stop` in RUN.
  - Required: IDLE, PC preserved.
- **Write protection and priority:**
  - Stimulus: `prog_we` during RUN, and `prog_we` together with `run` in IDLE.
  - Required: memory unchanged (read back via step).
  - Stimulus: `run` and `step` together.
  - Required: RUN from PC 0.
- **Reset mid-run:**
  - Stimulus: assert `reset_n`=0 for one edge while RUN is fetching.
  - Required: next cycle IDLE, `pc_out`=0, `instr_out`=8'h00, `instr_valid`=0, `halted`=0; subsequent step returns 8'h00.
